operand_entry_controller: RTL and testbench

- Front-end sequencer that drives the calculator's arithmetic datapath from raw board inputs.
- Synchronizes and debounces two active-low pushbuttons, Enter and Cancel.
- Runs an entry FSM that captures switch operands.
- Emits single-cycle load strobes InA, InB, Out and Clear, plus a held Add_Subtract select, toward the operand/result registers.

---
 rtl/operand_entry_controller_if.sv | 27 ++
 rtl/operand_entry_controller.sv | 143 ++++++++++++++
 tb/tb_operand_entry_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/operand_entry_controller_if.sv
// Board-side pins of the operand entry controller, seen from the
// controller (slave) and from whatever drives the keys and switches (master).
interface operand_entry_controller_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  KeyEnter_n;
    logic                  KeyCancel_n;
    logic [DATA_WIDTH-1:0] SW;
    logic                  SubSel;
    logic [DATA_WIDTH-1:0] X;
    logic                  InA;
    logic                  InB;
    logic                  Out;
    logic                  Clear;
    logic                  Add_Subtract;
    logic [1:0]            State;

    modport master (
        output KeyEnter_n, KeyCancel_n, SW, SubSel,
        input  X, InA, InB, Out, Clear, Add_Subtract, State
    );

    modport slave (
        input  KeyEnter_n, KeyCancel_n, SW, SubSel,
        output X, InA, InB, Out, Clear, Add_Subtract, State
    );
endinterface

// File: rtl/operand_entry_controller.sv
// Calculator front end: synchronizes and debounces Enter/Cancel, then walks
// the operand entry sequence and issues one-cycle load strobes to the datapath.
//
// state    | meaning
// ---------+-------------------------------------------------------
// WAIT_A   | waiting for Enter to capture operand A from SW
// WAIT_B   | waiting for Enter to capture operand B and SubSel
// WAIT_OUT | waiting for Enter to load the result/flags registers
// SHOW     | result displayed; Enter clears and restarts
module operand_entry_controller #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic                      Clock,
    input logic                      Reset,
    operand_entry_controller_if.slave io
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int K_ENTER  = 0;
    localparam int K_CANCEL = 1;

    typedef enum logic [1:0] {
        WAIT_A   = 2'd0,
        WAIT_B   = 2'd1,
        WAIT_OUT = 2'd2,
        SHOW     = 2'd3
    } state_t;

    logic [1:0]            key_raw;
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            deb_q;
    logic [1:0]            deb_d;
    logic [1:0]            evt_q;
    logic [1:0]            evt_d;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic                  add_sub_q;
    logic                  ina_q;
    logic                  inb_q;
    logic                  out_q;
    logic                  clear_q;
    logic                  first_q;

    assign key_raw = {io.KeyCancel_n, io.KeyEnter_n};

    // Levels are 1 = released; an event fires only on the transition to pressed.
    always_comb begin
        deb_d = deb_q;
        evt_d = '0;
        cnt_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    deb_d[k] = sync2_q[k];
                    evt_d[k] = ~sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            cnt_q   <= '0;
            evt_q   <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= WAIT_A;
            x_q       <= '0;
            add_sub_q <= 1'b0;
            ina_q     <= 1'b0;
            inb_q     <= 1'b0;
            out_q     <= 1'b0;
            clear_q   <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            ina_q   <= 1'b0;
            inb_q   <= 1'b0;
            out_q   <= 1'b0;
            clear_q <= 1'b0;
            if (first_q) begin
                first_q <= 1'b0;
                clear_q <= 1'b1;
            end else if (evt_q[K_CANCEL]) begin
                // Cancel beats a simultaneous Enter.
                state_q <= WAIT_A;
                clear_q <= 1'b1;
            end else if (evt_q[K_ENTER]) begin
                case (state_q)
                    WAIT_A: begin
                        x_q     <= io.SW;
                        ina_q   <= 1'b1;
                        state_q <= WAIT_B;
                    end
                    WAIT_B: begin
                        x_q       <= io.SW;
                        add_sub_q <= io.SubSel;
                        inb_q     <= 1'b1;
                        state_q   <= WAIT_OUT;
                    end
                    WAIT_OUT: begin
                        out_q   <= 1'b1;
                        state_q <= SHOW;
                    end
                    SHOW: begin
                        clear_q <= 1'b1;
                        state_q <= WAIT_A;
                    end
                    default: state_q <= WAIT_A;
                endcase
            end
        end
    end

    assign io.X            = x_q;
    assign io.InA          = ina_q;
    assign io.InB          = inb_q;
    assign io.Out          = out_q;
    assign io.Clear        = clear_q;
    assign io.Add_Subtract = add_sub_q;
    assign io.State        = state_q;

endmodule

// File: tb/tb_operand_entry_controller.sv
// Directed bench for operand_entry_controller with a short debounce window:
// a vector table of key presses plus hand-written reset and bounce sequences.
module tb_operand_entry_controller;

    logic clk;
    logic rst;

    operand_entry_controller_if #(.DATA_WIDTH(8)) bus ();

    operand_entry_controller #(
        .DATA_WIDTH     (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       ca;
        logic [7:0] sw;
        logic       sub;
        int         hold;
        int         win;
        int         e_ina;
        int         e_inb;
        int         e_out;
        int         e_clr;
        logic [7:0] e_x;
        logic       e_as;
        logic [1:0] e_st;
    } vec_t;

    vec_t vecs[14];

    int         checks = 0;
    int         errors = 0;
    int         n_ina, n_inb, n_out, n_clr;
    logic       multi;
    logic       seen;
    logic [7:0] x_seen;
    logic       as_seen;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the key levels cycle by cycle from the patterns and tallies strobes.
    task automatic apply(input logic [63:0] en_pat, input logic [63:0] ca_pat, input int len);
        int s;
        n_ina = 0; n_inb = 0; n_out = 0; n_clr = 0;
        multi = 1'b0; seen = 1'b0;
        for (int c = 0; c < len; c++) begin
            bus.KeyEnter_n  = en_pat[c];
            bus.KeyCancel_n = ca_pat[c];
            tick();
            s = int'(bus.InA) + int'(bus.InB) + int'(bus.Out) + int'(bus.Clear);
            if (bus.InA)   n_ina++;
            if (bus.InB)   n_inb++;
            if (bus.Out)   n_out++;
            if (bus.Clear) n_clr++;
            if (s > 1) multi = 1'b1;
            if (s > 0) begin
                seen    = 1'b1;
                x_seen  = bus.X;
                as_seen = bus.Add_Subtract;
            end
        end
        if (!seen) begin
            x_seen  = bus.X;
            as_seen = bus.Add_Subtract;
        end
        bus.KeyEnter_n  = 1'b1;
        bus.KeyCancel_n = 1'b1;
    endtask

    task automatic press(input logic en, input logic ca, input int hold, input int win);
        logic [63:0] ep;
        logic [63:0] cp;
        for (int c = 0; c < 64; c++) begin
            ep[c] = !(en && c < hold);
            cp[c] = !(ca && c < hold);
        end
        apply(ep, cp, win);
    endtask

    initial begin
        logic [63:0] ep;
        logic [63:0] cp;

        //            en ca  sw     sub hold win ina inb out clr x      as st
        vecs[0]  = '{1, 0, 8'h25, 0,  8,  20, 1,  0,  0,  0,  8'h25, 0, 2'd1};
        vecs[1]  = '{1, 0, 8'h13, 0,  8,  20, 0,  1,  0,  0,  8'h13, 0, 2'd2};
        vecs[2]  = '{1, 0, 8'hFF, 1,  8,  20, 0,  0,  1,  0,  8'h13, 0, 2'd3};
        vecs[3]  = '{1, 0, 8'hEE, 1,  8,  20, 0,  0,  0,  1,  8'h13, 0, 2'd0};
        vecs[4]  = '{1, 0, 8'h40, 1,  8,  20, 1,  0,  0,  0,  8'h40, 0, 2'd1};
        vecs[5]  = '{1, 0, 8'h07, 1,  8,  20, 0,  1,  0,  0,  8'h07, 1, 2'd2};
        vecs[6]  = '{1, 0, 8'h07, 0,  8,  20, 0,  0,  1,  0,  8'h07, 1, 2'd3};
        vecs[7]  = '{1, 0, 8'h07, 0,  8,  20, 0,  0,  0,  1,  8'h07, 1, 2'd0};
        vecs[8]  = '{1, 0, 8'h5A, 1,  3,  20, 0,  0,  0,  0,  8'h07, 1, 2'd0};
        vecs[9]  = '{1, 0, 8'h5A, 1,  50, 64, 1,  0,  0,  0,  8'h5A, 1, 2'd1};
        vecs[10] = '{1, 0, 8'h33, 0,  8,  20, 0,  1,  0,  0,  8'h33, 0, 2'd2};
        vecs[11] = '{0, 1, 8'h99, 1,  8,  20, 0,  0,  0,  1,  8'h33, 0, 2'd0};
        vecs[12] = '{1, 0, 8'h11, 1,  8,  20, 1,  0,  0,  0,  8'h11, 0, 2'd1};
        vecs[13] = '{1, 1, 8'h22, 1,  8,  20, 0,  0,  0,  1,  8'h11, 0, 2'd0};

        rst             = 1'b1;
        bus.KeyEnter_n  = 1'b1;
        bus.KeyCancel_n = 1'b1;
        bus.SW          = 8'h00;
        bus.SubSel      = 1'b0;

        repeat (3) tick();
        check("rst_x", bus.X, 0);
        check("rst_strobes", {bus.InA, bus.InB, bus.Out, bus.Clear}, 0);
        check("rst_as", bus.Add_Subtract, 0);
        check("rst_state", bus.State, 0);
        rst = 1'b0;
        tick();
        check("post_rst_clear", bus.Clear, 1);
        check("post_rst_other", {bus.InA, bus.InB, bus.Out}, 0);
        check("post_rst_state", bus.State, 0);
        tick();
        check("post_rst_clear_drop", bus.Clear, 0);

        for (int i = 0; i < 14; i++) begin
            bus.SW     = vecs[i].sw;
            bus.SubSel = vecs[i].sub;
            press(vecs[i].en, vecs[i].ca, vecs[i].hold, vecs[i].win);
            check($sformatf("v%0d_ina", i),   n_ina, vecs[i].e_ina);
            check($sformatf("v%0d_inb", i),   n_inb, vecs[i].e_inb);
            check($sformatf("v%0d_out", i),   n_out, vecs[i].e_out);
            check($sformatf("v%0d_clr", i),   n_clr, vecs[i].e_clr);
            check($sformatf("v%0d_multi", i), multi, 0);
            check($sformatf("v%0d_x", i),     x_seen, vecs[i].e_x);
            check($sformatf("v%0d_as", i),    as_seen, vecs[i].e_as);
            check($sformatf("v%0d_state", i), bus.State, vecs[i].e_st);
        end

        // Bounce: low 1, high 2, low 1, high 1, then stable low for 12 cycles.
        bus.SW     = 8'h6C;
        bus.SubSel = 1'b0;
        for (int c = 0; c < 64; c++) begin
            ep[c] = !(c == 0 || c == 3 || (c >= 5 && c <= 16));
            cp[c] = 1'b1;
        end
        apply(ep, cp, 30);
        check("bounce_ina", n_ina, 1);
        check("bounce_others", n_inb + n_out + n_clr, 0);
        check("bounce_x", x_seen, 8'h6C);
        check("bounce_state", bus.State, 1);

        bus.SW = 8'h13;
        press(1'b1, 1'b0, 8, 20);
        check("midrst_inb", n_inb, 1);
        check("midrst_x_before", bus.X, 8'h13);
        check("midrst_state_before", bus.State, 2);

        rst = 1'b1;
        tick();
        check("midrst_x", bus.X, 0);
        check("midrst_state", bus.State, 0);
        check("midrst_strobes", {bus.InA, bus.InB, bus.Out, bus.Clear}, 0);
        rst = 1'b0;
        tick();
        check("midrst_clear", bus.Clear, 1);
        check("midrst_out_at_clear", bus.Out, 0);
        check("midrst_x_after", bus.X, 0);
        press(1'b0, 1'b0, 0, 20);
        check("midrst_idle_out", n_out, 0);
        check("midrst_idle_clr", n_clr, 0);
        check("midrst_idle_state", bus.State, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
